stage_permutation_stream: RTL
=============================

STAGE_PERMUTATION_STREAM -- requirements
Module: stage_permutation_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per coefficient.
REQ-002 SHALL have parameter LANES, default 32, coefficients per beat; power of two, at least 2; LOG2_LANES = log2(LANES).
REQ-003 SHALL have parameter FRAME_BEATS, default 32, beats per frame; at least 1.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit, input beat present.
REQ-007 SHALL have port in_ready, output, 1 bit, block can accept a beat.
REQ-008 SHALL have port in_data, input, LANES*DATA_WIDTH bits; lane i occupies [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port in_stage, input, $clog2(LANES)+1 bits, permutation selector sampled at frame start.
REQ-010 SHALL have port out_valid, output, 1 bit, output beat present.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream accepts a beat.
REQ-012 SHALL have port out_data, output, LANES*DATA_WIDTH bits, permuted beat; lane packing as in_data.
REQ-013 SHALL have port out_last, output, 1 bit, qualifies the final beat of a frame.
REQ-014 SHALL have port err_stage, output, 1 bit, sticky illegal-stage flag.

Function
REQ-015 SHALL accept a beat when in_valid and in_ready are both 1 in the same cycle, and deliver it when out_valid and out_ready are both 1.
REQ-016 SHALL compute the permuted beat as out lane j = in lane rotl(j, s), where rotl rotates the LOG2_LANES-bit index j left by s bits, and s is the frame stage.
REQ-017 SHALL treat s = 0 as the identity permutation.
REQ-018 SHALL keep a frame beat counter of accepted beats, 0..FRAME_BEATS-1, which wraps to 0 after FRAME_BEATS-1.
REQ-019 SHALL latch in_stage as the frame stage on the accepted beat with counter = 0, and hold it for the rest of the frame; in_stage on later beats is ignored.
REQ-020 SHALL treat a latched in_stage >= LOG2_LANES as stage 0 for that frame and set err_stage to 1; err_stage stays 1 until reset.
REQ-021 SHALL attach a last tag to the beat accepted with counter = FRAME_BEATS-1; out_last = out_valid and the tag of the head entry.
REQ-022 SHALL register permuted beats into a 2-entry FIFO (data plus last tag) with occupancy 0..2.
REQ-023 SHALL drive in_ready = (occupancy < 2) from registered state only, with no combinational path from out_ready.
REQ-024 SHALL drive out_valid = (occupancy > 0), with out_data and out_last taken from the head entry.
REQ-025 SHALL make a beat accepted at edge t visible on out_valid and out_data after edge t when the FIFO was empty: 1-cycle latency.
REQ-026 SHALL, on a simultaneous accept and deliver, leave occupancy unchanged and preserve order; with occupancy 1 the new beat becomes the head after the old head leaves.
REQ-027 SHALL hold out_data and out_last stable while out_valid = 1 and out_ready = 0.
REQ-028 SHALL sustain one beat per cycle when out_ready is held at 1.
REQ-029 SHALL not change occupancy or the counter when no handshake occurs.

Reset
REQ-030 SHALL, while rst = 0, asynchronously clear occupancy, the frame counter, the latched stage, err_stage, all FIFO data and tags, and out_data.
REQ-031 SHALL give out_valid = 0, out_last = 0, out_data = 0, err_stage = 0 and in_ready = 1 during reset.
REQ-032 SHALL discard buffered beats when reset is asserted mid-frame; the first accepted beat after release starts a new frame at counter 0.

Verification (LANES=4, DATA_WIDTH=8, FRAME_BEATS=4)
REQ-033 SHALL cover: stage 1, in lanes 0..3 = 0x10,0x11,0x12,0x13, out_ready = 1 -> one cycle later out lanes 0..3 = 0x10,0x12,0x11,0x13.
REQ-034 SHALL cover: 4 back-to-back beats, stage 0 latched on beat 0, in_stage changed to 1 on beats 1-3 -> all outputs identity; out_last = 1 only on beat 3; beat 4 uses a newly latched stage.
REQ-035 SHALL cover: out_ready = 0 with 3 beats offered -> 2 beats accepted, in_ready = 0, out_data frozen on beat 0; release out_ready -> beats delivered in order with none lost.
REQ-036 SHALL cover: in_stage = 2 at frame start -> identity output and err_stage = 1, still 1 after later legal frames.
REQ-037 SHALL cover: rst pulsed low after 2 beats buffered mid-frame -> out_valid = 0 immediately; the next accepted beat has counter = 0, and out_last occurs on the 4th beat after reset.
REQ-038 SHALL cover: continuous valid/ready for 8 beats -> 8 outputs on 8 consecutive cycles, out_last on outputs 4 and 8.

Source files
------------

// File: rtl/stage_permutation_stream.sv
// Streaming lane permutation: each beat's lanes are reordered by rotating the lane
// index left by a per-frame stage, then buffered in a 2-entry output FIFO.
module stage_permutation_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int LANES       = 32,
  parameter int FRAME_BEATS = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]    in_data,
  input  logic [$clog2(LANES):0]         in_stage,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*DATA_WIDTH-1:0]    out_data,
  output logic                           out_last,
  output logic                           err_stage
);

  localparam int LOG2_LANES = $clog2(LANES);
  localparam int SW         = LOG2_LANES + 1;
  localparam int BW         = LANES * DATA_WIDTH;
  localparam int CW         = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  // Handshake: a beat moves on any rising edge where valid and ready are both 1.
  // in_ready depends only on FIFO occupancy, never on out_ready.

  logic [1:0]            r_count;
  logic [CW-1:0]         r_beat;
  logic [LOG2_LANES-1:0] r_stage;
  logic                  r_err;
  logic [BW-1:0]         r_data0;
  logic [BW-1:0]         r_data1;
  logic                  r_last0;
  logic                  r_last1;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_frame_start;
  logic                  w_stage_bad;
  logic [LOG2_LANES-1:0] w_stage_new;
  logic [LOG2_LANES-1:0] w_stage;
  logic                  w_last;
  logic [BW-1:0]         w_perm;

  function automatic logic [LOG2_LANES-1:0] rotl(input logic [LOG2_LANES-1:0] j,
                                                 input logic [LOG2_LANES-1:0] s);
    logic [2*LOG2_LANES-1:0] dbl;
    dbl = {j, j} << s;
    return dbl[2*LOG2_LANES-1 -: LOG2_LANES];
  endfunction

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_data0;
  assign out_last  = out_valid & r_last0;
  assign err_stage = r_err;

  assign w_push        = in_valid & in_ready;
  assign w_pop         = out_valid & out_ready;
  assign w_frame_start = (r_beat == '0);
  assign w_last        = (r_beat == CW'(FRAME_BEATS - 1));
  assign w_stage_bad   = (in_stage >= SW'(LOG2_LANES));
  assign w_stage_new   = w_stage_bad ? '0 : in_stage[LOG2_LANES-1:0];
  // The first beat of a frame is permuted with the stage it brings along.
  assign w_stage       = w_frame_start ? w_stage_new : r_stage;

  always_comb begin
    w_perm = '0;
    for (int j = 0; j < LANES; j++) begin
      w_perm[j*DATA_WIDTH +: DATA_WIDTH] =
        in_data[int'(rotl(LOG2_LANES'(j), w_stage))*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat  <= '0;
      r_stage <= '0;
      r_err   <= 1'b0;
    end else if (w_push) begin
      r_beat <= w_last ? '0 : r_beat + CW'(1);
      if (w_frame_start) begin
        r_stage <= w_stage_new;
        if (w_stage_bad) r_err <= 1'b1;
      end
    end
  end

  // Entry 0 is always the head; entry 1 only holds a beat when occupancy is 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 2'd0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_data0 <= w_perm;
            r_last0 <= w_last;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_data0 <= w_perm;
            r_last0 <= w_last;
          end else if (w_push) begin
            r_data1 <= w_perm;
            r_last1 <= w_last;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_count <= 2'd1;
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

endmodule
